// File: rtl/trace_sequencer.sv
// Walks the branch-trace store entry by entry, feeding each branch to the predictor,
// training it with the real outcome and keeping branch / mispredict statistics.
//
// state     | meaning
// IDLE      | waiting for start after reset
// FETCH     | trace index presented to the store
// LOAD      | store output settles; captured on exit
// REQUEST   | lookup request held until PredReady
// WAIT_PRED | waiting for the predictor's answer
// UPDATE    | one-cycle training pulse, statistics update
// DONE      | run complete, results held until next start
module trace_sequencer #(
    parameter int ADDRESS_SIZE           = 8,
    parameter int TRAINING_DATA_SIZE     = 3898078,
    parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
    parameter int COUNT_SIZE             = 32
) (
    input  logic                              Clk,
    input  logic                              reset,
    input  logic                              start,
    output logic [INSTRUCTION_INDEX_SIZE-1:0] InstructionNumber,
    input  logic [ADDRESS_SIZE-1:0]           BranchAddress,
    input  logic                              BranchResult,
    output logic [ADDRESS_SIZE-1:0]           PredAddress,
    output logic                              PredValid,
    input  logic                              PredReady,
    input  logic                              Prediction,
    input  logic                              PredictionValid,
    output logic                              UpdateValid,
    output logic                              UpdateTaken,
    output logic [ADDRESS_SIZE-1:0]           UpdateAddress,
    output logic                              Busy,
    output logic                              Done,
    output logic [COUNT_SIZE-1:0]             BranchCount,
    output logic [COUNT_SIZE-1:0]             MispredictCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_REQUEST,
        S_WAIT_PRED,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [INSTRUCTION_INDEX_SIZE-1:0] LAST_INDEX =
        INSTRUCTION_INDEX_SIZE'(TRAINING_DATA_SIZE - 1);
    localparam logic [COUNT_SIZE-1:0] COUNT_MAX = '1;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] cap_address;
    logic                    cap_result;
    logic                    pred_bit;

    assign PredValid   = (state == S_REQUEST);
    assign UpdateValid = (state == S_UPDATE);
    assign Busy        = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            InstructionNumber <= '0;
            PredAddress       <= '0;
            UpdateTaken       <= 1'b0;
            UpdateAddress     <= '0;
            Done              <= 1'b0;
            BranchCount       <= '0;
            MispredictCount   <= '0;
            cap_address       <= '0;
            cap_result        <= 1'b0;
            pred_bit          <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        InstructionNumber <= '0;
                        BranchCount       <= '0;
                        MispredictCount   <= '0;
                        Done              <= 1'b0;
                        state             <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    // The store has settled two cycles after the index moved.
                    cap_address <= BranchAddress;
                    cap_result  <= BranchResult;
                    PredAddress <= BranchAddress;
                    state       <= S_REQUEST;
                end
                S_REQUEST: begin
                    if (PredReady) begin
                        PredAddress <= '0;
                        state       <= S_WAIT_PRED;
                    end
                end
                S_WAIT_PRED: begin
                    if (PredictionValid) begin
                        pred_bit      <= Prediction;
                        UpdateTaken   <= cap_result;
                        UpdateAddress <= cap_address;
                        state         <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    UpdateTaken   <= 1'b0;
                    UpdateAddress <= '0;
                    if (BranchCount != COUNT_MAX) begin
                        BranchCount <= BranchCount + COUNT_SIZE'(1);
                    end
                    if ((pred_bit != cap_result) && (MispredictCount != COUNT_MAX)) begin
                        MispredictCount <= MispredictCount + COUNT_SIZE'(1);
                    end
                    if (InstructionNumber == LAST_INDEX) begin
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        InstructionNumber <= InstructionNumber + INSTRUCTION_INDEX_SIZE'(1);
                        state             <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
